mem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency unified memory between the fetch requester (read-only) and the memory-stage requester (load/store). It supports one outstanding transaction. Data requests have priority, and a starvation guard bounds how long fetch can wait. The pipeline stall logic consumes the grant/valid handshakes to hold F or M until their access completes.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_priority.sv | 33 +++
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Contents:
//   owner_t     - which requester owns the outstanding transaction
//   arb_state_t - arbiter state (idle / transaction outstanding)
//   FETCH_BE    - byte enables driven for every fetch command
package mem_arb_pkg;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational winner select between the fetch and data requesters.
// Data wins a contested slot unless the data streak has reached its limit,
// in which case fetch is forced through.
// Ports:
//   fetch_req  - fetch request, already qualified with issue eligibility
//   data_req   - data request, already qualified with issue eligibility
//   streak_max - data streak counter is at its maximum
//   gnt        - one-hot grant: bit 0 = fetch, bit 1 = data, 2'b00 = none
module mem_arb_priority (
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       streak_max,
    output logic [1:0] gnt
);

    // Fixed priority with the starvation override for fetch
    always_comb begin
        gnt = 2'b00;
        case ({fetch_req, data_req})
            2'b01:   gnt = 2'b10;
            2'b10:   gnt = 2'b01;
            2'b11: begin
                if (streak_max) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch requester
// (read-only) and the memory-stage requester (load/store). At most one
// transaction is outstanding; a new command may issue when idle or in the
// response cycle of the current one, giving one transaction per
// MEM_LATENCY cycles back-to-back.
// Ports:
//   iClk, iRst                    - clock, asynchronous active-low reset
//   iFetchReq/iFetchAddr          - fetch read request
//   iFetchFlush                   - drop the response of an outstanding fetch
//   oFetchGnt/oFetchValid/oFetchData - fetch command issued / read data
//   iDataReq/iDataWe/iDataAddr/iDataWData/iDataBe - load/store request
//   oDataGnt/oDataValid/oDataRData   - data command issued / completion
//   oMemEn/oMemWe/oMemAddr/oMemWData/oMemBe - memory command
//   iMemRData                     - memory read data, MEM_LATENCY after command
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 3,
    parameter int ADDR_W          = 32
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iFetchReq,
    input  logic [ADDR_W-1:0] iFetchAddr,
    input  logic              iFetchFlush,
    output logic              oFetchGnt,
    output logic              oFetchValid,
    output logic [31:0]       oFetchData,
    input  logic              iDataReq,
    input  logic              iDataWe,
    input  logic [ADDR_W-1:0] iDataAddr,
    input  logic [31:0]       iDataWData,
    input  logic [3:0]        iDataBe,
    output logic              oDataGnt,
    output logic              oDataValid,
    output logic [31:0]       oDataRData,
    output logic              oMemEn,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [31:0]       oMemWData,
    output logic [3:0]        oMemBe,
    input  logic [31:0]       iMemRData
);

    localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    owner_t              owner_r;
    logic                we_r;
    logic                flush_r;
    logic [STREAK_W-1:0] streak_r;

    logic                resp_s;
    logic                issue_ok_s;
    logic                streak_max_s;
    logic [1:0]          gnt_s;
    logic                fetch_gnt_s;
    logic                data_gnt_s;
    logic                any_gnt_s;

    // The response cycle doubles as an issue slot for the next command
    assign resp_s       = (state_r == ARB_BUSY) && (cnt_r == CNT_ONE);
    assign issue_ok_s   = (state_r == ARB_IDLE) || resp_s;
    assign streak_max_s = (streak_r == STREAK_MAX);

    mem_arb_priority u_priority (
        .fetch_req  (iFetchReq & issue_ok_s),
        .data_req   (iDataReq & issue_ok_s),
        .streak_max (streak_max_s),
        .gnt        (gnt_s)
    );

    assign fetch_gnt_s = gnt_s[0];
    assign data_gnt_s  = gnt_s[1];
    assign any_gnt_s   = fetch_gnt_s | data_gnt_s;

    // State register
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: stay busy while a command is issued in the response cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (any_gnt_s) begin
                    state_nxt_s = ARB_BUSY;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (resp_s && !any_gnt_s) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_BUSY;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // Transaction context: latency counter, owner, store flag, flush mark
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            cnt_r   <= '0;
            owner_r <= OWNER_FETCH;
            we_r    <= 1'b0;
            flush_r <= 1'b0;
        end else if (any_gnt_s) begin
            // A flush in the grant cycle belongs to the previous fetch only
            cnt_r   <= CNT_LOAD;
            owner_r <= data_gnt_s ? OWNER_DATA : OWNER_FETCH;
            we_r    <= data_gnt_s & iDataWe;
            flush_r <= 1'b0;
        end else if (state_r == ARB_BUSY) begin
            if (!resp_s) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            flush_r <= flush_r | iFetchFlush;
        end else begin
            cnt_r   <= cnt_r;
            flush_r <= flush_r;
        end
    end

    // Data streak: counts data wins while fetch is kept waiting
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            streak_r <= '0;
        end else if (!iFetchReq || fetch_gnt_s) begin
            streak_r <= '0;
        end else if (data_gnt_s && !streak_max_s) begin
            streak_r <= streak_r + STREAK_ONE;
        end else begin
            streak_r <= streak_r;
        end
    end

    // Outputs: memory command from the winner, response routed to the owner
    always_comb begin
        oFetchGnt   = 1'b0;
        oDataGnt    = 1'b0;
        oMemEn      = 1'b0;
        oMemWe      = 1'b0;
        oMemAddr    = '0;
        oMemWData   = 32'h0000_0000;
        oMemBe      = 4'h0;
        oFetchValid = 1'b0;
        oFetchData  = 32'h0000_0000;
        oDataValid  = 1'b0;
        oDataRData  = 32'h0000_0000;
        if (iRst) begin
            oFetchGnt = fetch_gnt_s;
            oDataGnt  = data_gnt_s;
            oMemEn    = any_gnt_s;
            if (data_gnt_s) begin
                oMemWe    = iDataWe;
                oMemAddr  = iDataAddr;
                oMemWData = iDataWData;
                oMemBe    = iDataBe;
            end else if (fetch_gnt_s) begin
                oMemWe    = 1'b0;
                oMemAddr  = iFetchAddr;
                oMemWData = 32'h0000_0000;
                oMemBe    = FETCH_BE;
            end else begin
                oMemWe = 1'b0;
            end
            // A flush in the response cycle itself still suppresses the fetch
            if (resp_s && (owner_r == OWNER_FETCH) && !flush_r && !iFetchFlush) begin
                oFetchValid = 1'b1;
                oFetchData  = iMemRData;
            end else begin
                oFetchValid = 1'b0;
            end
            if (resp_s && (owner_r == OWNER_DATA)) begin
                oDataValid = 1'b1;
                oDataRData = we_r ? 32'h0000_0000 : iMemRData;
            end else begin
                oDataValid = 1'b0;
            end
        end else begin
            oFetchGnt = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. A cycle-numbered reference model
// decides grants from the arbitration rules and pushes expected commands and
// responses (with due cycle) into queues; an independent negedge monitor pops
// and compares against what the DUT presents.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int MAXS = 3;

    logic        iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic        iRst;
    logic        iFetchReq, iFetchFlush, iDataReq, iDataWe;
    logic [31:0] iFetchAddr, iDataAddr, iDataWData, iMemRData;
    logic [3:0]  iDataBe;
    logic        oFetchGnt, oFetchValid, oDataGnt, oDataValid, oMemEn, oMemWe;
    logic [31:0] oFetchData, oDataRData, oMemAddr, oMemWData;
    logic [3:0]  oMemBe;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_DATA_STREAK(MAXS), .ADDR_W(32)) u_dut (
        .iClk(iClk), .iRst(iRst),
        .iFetchReq(iFetchReq), .iFetchAddr(iFetchAddr), .iFetchFlush(iFetchFlush),
        .oFetchGnt(oFetchGnt), .oFetchValid(oFetchValid), .oFetchData(oFetchData),
        .iDataReq(iDataReq), .iDataWe(iDataWe), .iDataAddr(iDataAddr),
        .iDataWData(iDataWData), .iDataBe(iDataBe),
        .oDataGnt(oDataGnt), .oDataValid(oDataValid), .oDataRData(oDataRData),
        .oMemEn(oMemEn), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemWData(oMemWData), .oMemBe(oMemBe), .iMemRData(iMemRData)
    );

    // Second instance for the single-cycle latency case (fetch only)
    logic        f1_req;
    logic [31:0] f1_addr, r1_data;
    logic        z1_bit = 1'b0;
    logic [31:0] z1_word = 32'h0;
    logic [3:0]  z1_be = 4'h0;
    logic        g1_fetch, v1_fetch, g1_data, v1_data, en1, we1;
    logic [31:0] d1_fetch, d1_data, addr1, wdata1;
    logic [3:0]  be1;

    mem_port_arbiter #(.MEM_LATENCY(1), .MAX_DATA_STREAK(MAXS), .ADDR_W(32)) u_dut1 (
        .iClk(iClk), .iRst(iRst),
        .iFetchReq(f1_req), .iFetchAddr(f1_addr), .iFetchFlush(z1_bit),
        .oFetchGnt(g1_fetch), .oFetchValid(v1_fetch), .oFetchData(d1_fetch),
        .iDataReq(z1_bit), .iDataWe(z1_bit), .iDataAddr(z1_word),
        .iDataWData(z1_word), .iDataBe(z1_be),
        .oDataGnt(g1_data), .oDataValid(v1_data), .oDataRData(d1_data),
        .oMemEn(en1), .oMemWe(we1), .oMemAddr(addr1),
        .oMemWData(wdata1), .oMemBe(be1), .iMemRData(r1_data)
    );

    typedef struct {
        int due;
        bit flushed;
        bit we;
    } resp_t;

    typedef struct {
        bit          fg;
        bit          dg;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    cmd_t  cmd_q[$];
    resp_t fq[$];
    resp_t dq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_resp_cyc = -1;
    int m_streak   = 0;
    bit m_fgnt, m_dgnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus plus the reference model's decision for it
    task automatic run_cycle(input bit freq, input logic [31:0] faddr,
                             input bit dreq, input bit dwe, input logic [31:0] daddr,
                             input logic [31:0] dwdata, input logic [3:0] dbe,
                             input bit flush);
        cmd_t  c;
        resp_t r;
        bit    elig;
        @(posedge iClk);
        #1;
        cyc++;
        iRst = 1'b1;
        iFetchReq = freq;  iFetchAddr = faddr;  iFetchFlush = flush;
        iDataReq = dreq;   iDataWe = dwe;       iDataAddr = daddr;
        iDataWData = dwdata; iDataBe = dbe;
        iMemRData = $urandom;
        // flush hits every fetch already outstanding, not one granted now
        if (flush) begin
            for (int i = 0; i < fq.size(); i++) fq[i].flushed = 1'b1;
        end
        elig = (m_resp_cyc < 0) || (m_resp_cyc == cyc);
        m_fgnt = 1'b0;
        m_dgnt = 1'b0;
        if (elig) begin
            if (dreq && !(freq && m_streak == MAXS)) m_dgnt = 1'b1;
            else if (freq) m_fgnt = 1'b1;
        end
        if (!freq || m_fgnt) m_streak = 0;
        else if (m_dgnt && m_streak < MAXS) m_streak++;
        c.fg = m_fgnt;
        c.dg = m_dgnt;
        c.addr = m_dgnt ? daddr : faddr;
        c.we = m_dgnt & dwe;
        c.wdata = dwdata;
        c.be = m_dgnt ? dbe : 4'hF;
        cmd_q.push_back(c);
        if (m_fgnt || m_dgnt) begin
            r.due = cyc + LAT;
            r.flushed = 1'b0;
            r.we = c.we;
            if (m_fgnt) fq.push_back(r);
            else dq.push_back(r);
            m_resp_cyc = cyc + LAT;
        end else if (m_resp_cyc == cyc) begin
            m_resp_cyc = -1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    // Assert reset for n cycles; everything outstanding is forgotten
    task automatic do_reset(input int n);
        @(posedge iClk);
        #1;
        cyc++;
        iRst = 1'b0;
        iFetchReq = 1'b0; iDataReq = 1'b0; iFetchFlush = 1'b0;
        cmd_q.delete();
        fq.delete();
        dq.delete();
        m_resp_cyc = -1;
        m_streak = 0;
        #1;
        chk("async_rst_ctl", 32'({oFetchGnt, oDataGnt, oMemEn, oMemWe, oFetchValid, oDataValid}), 32'h0);
        chk("async_rst_addr", oMemAddr, 32'h0);
        chk("async_rst_data", oFetchData | oDataRData | oMemWData, 32'h0);
        for (int i = 1; i < n; i++) begin
            @(posedge iClk);
            #1;
            cyc++;
        end
    endtask

    // Monitor: compares each cycle's command and any due response
    cmd_t  mon_c;
    resp_t mon_r;
    bit    mon_efv, mon_edv;
    logic [31:0] mon_edd;

    always @(negedge iClk) begin
        if (!iRst) begin
            chk("rst_ctl", 32'({oFetchGnt, oDataGnt, oMemEn, oMemWe, oFetchValid, oDataValid}), 32'h0);
            chk("rst_bus", oMemAddr | oMemWData | 32'(oMemBe), 32'h0);
        end else begin
            if (cmd_q.size() > 0) begin
                mon_c = cmd_q.pop_front();
                chk("fetch_gnt", 32'(oFetchGnt), 32'(mon_c.fg));
                chk("data_gnt", 32'(oDataGnt), 32'(mon_c.dg));
                chk("mem_en", 32'(oMemEn), 32'(mon_c.fg | mon_c.dg));
                if (mon_c.fg || mon_c.dg) begin
                    chk("mem_addr", oMemAddr, mon_c.addr);
                    chk("mem_we", 32'(oMemWe), 32'(mon_c.we));
                    chk("mem_be", 32'(oMemBe), 32'(mon_c.be));
                    if (mon_c.we) chk("mem_wdata", oMemWData, mon_c.wdata);
                end
            end
            mon_efv = 1'b0;
            if (fq.size() > 0 && fq[0].due <= cyc) begin
                mon_r = fq.pop_front();
                mon_efv = !mon_r.flushed;
            end
            chk("fetch_valid", 32'(oFetchValid), 32'(mon_efv));
            if (mon_efv) chk("fetch_data", oFetchData, iMemRData);
            mon_edv = 1'b0;
            mon_edd = 32'h0;
            if (dq.size() > 0 && dq[0].due <= cyc) begin
                mon_r = dq.pop_front();
                mon_edv = 1'b1;
                mon_edd = mon_r.we ? 32'h0 : iMemRData;
            end
            chk("data_valid", 32'(oDataValid), 32'(mon_edv));
            if (mon_edv) chk("data_rdata", oDataRData, mon_edd);
        end
    end

    string seq;
    bit fp, dp, dwe_r;
    logic [31:0] fa, da, dw;
    logic [3:0]  dbe_r;

    initial begin
        iRst = 1'b0;
        iFetchReq = 1'b0; iFetchAddr = 32'h0; iFetchFlush = 1'b0;
        iDataReq = 1'b0; iDataWe = 1'b0; iDataAddr = 32'h0; iDataWData = 32'h0;
        iDataBe = 4'h0; iMemRData = 32'h0;
        f1_req = 1'b0; f1_addr = 32'h0; r1_data = 32'h0;
        repeat (3) @(posedge iClk);

        // fetch only, held: grants at 0 and 2, valids at 2 and 4
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        idle_cycles(3);

        // both requesting continuously: D,D,D,F,D,D,D,F
        seq = "";
        for (int i = 0; i < 16; i++) begin
            run_cycle(1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF, 1'b0);
            @(negedge iClk);
            if (oDataGnt) seq = {seq, "D"};
            if (oFetchGnt) seq = {seq, "F"};
        end
        n_checks++;
        if (seq != "DDDFDDDF") begin
            n_fail++;
            $display("FAIL grant_seq: got %s expected DDDFDDDF", seq);
        end
        idle_cycles(3);

        // store
        run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011, 1'b0);
        idle_cycles(3);

        // flush one cycle after grant, flush in the response cycle, flush at grant
        run_cycle(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        idle_cycles(2);
        run_cycle(1'b1, 32'h304, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        idle_cycles(1);
        run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        idle_cycles(1);
        run_cycle(1'b1, 32'h308, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        idle_cycles(3);

        // reset mid-flight: load granted, reset next cycle for two cycles
        run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h440, 32'h0, 4'hF, 1'b0);
        do_reset(2);
        idle_cycles(3);
        run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h444, 32'h0, 4'hF, 1'b0);
        idle_cycles(3);

        // randomized traffic with one reset in the middle
        fp = 1'b0; dp = 1'b0; fa = 32'h0; da = 32'h0; dw = 32'h0; dwe_r = 1'b0; dbe_r = 4'h0;
        for (int i = 0; i < 600; i++) begin
            if (!fp && ($urandom % 3 == 0)) begin
                fp = 1'b1; fa = $urandom & 32'hFFFF_FFFC;
            end else if (fp && ($urandom % 16 == 0)) begin
                fp = 1'b0;
            end
            if (!dp && ($urandom % 3 == 0)) begin
                dp = 1'b1; da = $urandom & 32'hFFFF_FFFC; dw = $urandom;
                dwe_r = 1'($urandom % 2); dbe_r = 4'($urandom);
            end else if (dp && ($urandom % 16 == 0)) begin
                dp = 1'b0;
            end
            if (i == 300) do_reset(2);
            run_cycle(fp, fa, dp, dwe_r, da, dw, dbe_r, ($urandom % 8 == 0));
            if (m_fgnt) fp = 1'b0;
            if (m_dgnt) dp = 1'b0;
        end
        idle_cycles(4);
        chk("fetch_drain", 32'(fq.size()), 32'h0);
        chk("data_drain", 32'(dq.size()), 32'h0);

        // single-cycle latency: fetch granted every cycle, valid the next
        for (int i = 0; i < 6; i++) begin
            @(posedge iClk);
            #1;
            f1_req = (i < 5);
            f1_addr = 32'h40 + 32'(4 * i);
            r1_data = $urandom;
            @(negedge iClk);
            chk("l1_gnt", 32'(g1_fetch), 32'(i < 5));
            chk("l1_valid", 32'(v1_fetch), 32'(i > 0));
            if (i > 0) chk("l1_data", d1_fetch, r1_data);
            if (i < 5) chk("l1_addr", addr1, 32'h40 + 32'(4 * i));
            chk("l1_misc", 32'({g1_data, v1_data, we1}) | d1_data | wdata1, 32'h0);
            chk("l1_en_be", 32'({en1, be1}), (i < 5) ? 32'h1F : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
